// File: rtl/map_ss_pkg.sv
// Shared types and constants for the mapper save-state sequencer.
package map_ss_pkg;

  localparam int unsigned SLOT_W      = 8;
  localparam int unsigned ID_ADDR_DEF = 127;
  localparam int unsigned TIMEOUT_LIM = 255;

  typedef enum logic [2:0] {
    IDLE,
    SV_RD,
    SV_WR,
    LD_ID,
    LD_RD,
    LD_WR,
    FIN
  } state_t;

  // Registered output bundle of the sequencer.
  typedef struct packed {
    logic              busy;
    logic              done;
    logic              err;
    logic              ss_act;
    logic              ss_we;
    logic [SLOT_W-1:0] ss_addr;
    logic [SLOT_W-1:0] ss_wdat;
    logic              mem_we;
    logic [SLOT_W-1:0] mem_addr;
    logic [SLOT_W-1:0] mem_wdat;
  } ss_out_t;

endpackage

// File: rtl/map_ss_hs.sv
// Backing-buffer request/acknowledge handshake.
// Optional watchdog enabled by defining SS_TIMEOUT_EN.
module map_ss_hs
  import map_ss_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic acked_c,
  output logic timeout_c
);

  assign acked_c = req & ack;

`ifdef SS_TIMEOUT_EN
  logic [7:0] wdog;

  // Fires in the cycle the request has been held TIMEOUT_LIM cycles unanswered.
  assign timeout_c = req & ~ack & (wdog == 8'(TIMEOUT_LIM - 1));

  // Request flag plus watchdog, reloaded on every new request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req  <= 1'b0;
      wdog <= 8'd0;
    end else if (req && (ack || timeout_c)) begin
      req  <= 1'b0;
      wdog <= 8'd0;
    end else if (start) begin
      req  <= 1'b1;
      wdog <= 8'd0;
    end else if (req) begin
      wdog <= wdog + 8'd1;
    end
  end
`else
  assign timeout_c = 1'b0;

  // Request flag: set on start, cleared by acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req <= 1'b0;
    end else if (req && ack) begin
      req <= 1'b0;
    end else if (start) begin
      req <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: copies mapper slots to a backing buffer
// (save) or restores them after an ID check (load).
// Optional buffer watchdog enabled by defining SS_TIMEOUT_EN.
module map_ss_seq
  import map_ss_pkg::*;
#(
  parameter int unsigned N_REGS  = 14,
  parameter int unsigned ID_ADDR = ID_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_save,
  input  logic              cmd_load,
  output logic              ss_act,
  output logic              ss_we,
  output logic [SLOT_W-1:0] ss_addr,
  output logic [SLOT_W-1:0] ss_wdat,
  input  logic [SLOT_W-1:0] ss_rdat,
  output logic              mem_req,
  output logic              mem_we,
  output logic [SLOT_W-1:0] mem_addr,
  output logic [SLOT_W-1:0] mem_wdat,
  input  logic              mem_ack,
  input  logic [SLOT_W-1:0] mem_rdat,
  output logic              busy,
  output logic              done,
  output logic              err
);

  if (N_REGS == 0 || N_REGS > ID_ADDR || ID_ADDR > 255) begin : g_bad_params
    $error("map_ss_seq: require 1 <= N_REGS <= ID_ADDR <= 255");
  end

  localparam logic [SLOT_W-1:0] LAST_REG = SLOT_W'(N_REGS - 1);
  localparam logic [SLOT_W-1:0] ID_SLOT  = SLOT_W'(ID_ADDR);

  state_t            state, state_n;
  logic [SLOT_W-1:0] slot, slot_n;
  ss_out_t           o_q, o_n;
  logic              hs_start_c, hs_acked_c, hs_timeout_c;

  map_ss_hs u_hs (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (hs_start_c),
    .ack       (mem_ack),
    .req       (mem_req),
    .acked_c   (hs_acked_c),
    .timeout_c (hs_timeout_c)
  );

  // Next state, slot and output values; outputs derive from the next state so
  // the registered outputs line up with the state they belong to.
  always_comb begin
    state_n    = state;
    slot_n     = slot;
    hs_start_c = 1'b0;
    o_n        = '0;
    o_n.err    = o_q.err;

    case (state)
      IDLE: begin
        if (cmd_save) begin
          state_n = SV_RD;
          slot_n  = '0;
          o_n.err = 1'b0;
        end else if (cmd_load) begin
          state_n    = LD_ID;
          slot_n     = '0;
          hs_start_c = 1'b1;
          o_n.err    = 1'b0;
        end
      end
      SV_RD: begin
        state_n    = SV_WR;
        hs_start_c = 1'b1;
      end
      SV_WR: begin
        if (hs_acked_c) begin
          if (slot == ID_SLOT) begin
            state_n = FIN;
          end else begin
            state_n = SV_RD;
            slot_n  = (slot == LAST_REG) ? ID_SLOT : slot + 8'd1;
          end
        end else if (hs_timeout_c) begin
          state_n = FIN;
          o_n.err = 1'b1;
        end
      end
      LD_ID: begin
        if (hs_acked_c) begin
          if (mem_rdat != ss_rdat) begin
            state_n = FIN;
            o_n.err = 1'b1;
          end else begin
            state_n = LD_RD;
            slot_n  = '0;
          end
        end else if (hs_timeout_c) begin
          state_n = FIN;
          o_n.err = 1'b1;
        end
      end
      LD_RD: begin
        // First cycle is the idle gap after the previous acknowledge.
        hs_start_c = ~mem_req;
        if (hs_acked_c) begin
          state_n = LD_WR;
        end else if (hs_timeout_c) begin
          state_n = FIN;
          o_n.err = 1'b1;
        end
      end
      LD_WR: begin
        if (slot == LAST_REG) begin
          state_n = FIN;
        end else begin
          state_n = LD_RD;
          slot_n  = slot + 8'd1;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

    o_n.busy = (state_n != IDLE);
    o_n.done = (state_n == FIN);
    case (state_n)
      SV_RD: begin
        o_n.ss_act  = 1'b1;
        o_n.ss_addr = slot_n;
      end
      SV_WR: begin
        o_n.ss_act   = 1'b1;
        o_n.ss_addr  = slot_n;
        o_n.mem_we   = 1'b1;
        o_n.mem_addr = slot_n;
        o_n.mem_wdat = (state == SV_RD) ? ss_rdat : o_q.mem_wdat;
      end
      LD_ID: begin
        o_n.ss_act   = 1'b1;
        o_n.ss_addr  = ID_SLOT;
        o_n.mem_addr = ID_SLOT;
      end
      LD_RD: begin
        o_n.ss_act   = 1'b1;
        o_n.ss_addr  = slot_n;
        o_n.mem_addr = slot_n;
      end
      LD_WR: begin
        o_n.ss_act  = 1'b1;
        o_n.ss_we   = 1'b1;
        o_n.ss_addr = slot_n;
        o_n.ss_wdat = mem_rdat;
      end
      default: ;
    endcase
  end

  // State, slot counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      slot  <= '0;
      o_q   <= '0;
    end else begin
      state <= state_n;
      slot  <= slot_n;
      o_q   <= o_n;
    end
  end

  assign busy     = o_q.busy;
  assign done     = o_q.done;
  assign err      = o_q.err;
  assign ss_act   = o_q.ss_act;
  assign ss_we    = o_q.ss_we;
  assign ss_addr  = o_q.ss_addr;
  assign ss_wdat  = o_q.ss_wdat;
  assign mem_we   = o_q.mem_we;
  assign mem_addr = o_q.mem_addr;
  assign mem_wdat = o_q.mem_wdat;

endmodule

// File: tb/tb_map_ss_seq.sv
// Directed bench for map_ss_seq with a mapper register model and a
// backing-buffer responder acknowledging two cycles after each request.
module tb_map_ss_seq;

  logic       clk = 1'b0;
  logic       rst_n, cmd_save, cmd_load;
  logic       ss_act, ss_we, mem_req, mem_we, busy, done, err;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, mem_addr, mem_wdat;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdat = 8'd0;

  always #5 clk = ~clk;

  map_ss_seq #(.N_REGS(14), .ID_ADDR(127)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_save (cmd_save),
    .cmd_load (cmd_load),
    .ss_act   (ss_act),
    .ss_we    (ss_we),
    .ss_addr  (ss_addr),
    .ss_wdat  (ss_wdat),
    .ss_rdat  (ss_rdat),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdat (mem_wdat),
    .mem_ack  (mem_ack),
    .mem_rdat (mem_rdat),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  logic [7:0] mreg [256];
  logic [7:0] bmem [256];
  logic [7:0] wr_addr [32];
  int         scen = 0;
  logic       init_req = 1'b0;
  logic       ack_en = 1'b1;
  int         we_cnt = 0, wr127 = 0, done_cnt = 0, overlap = 0, wr_n = 0;
  logic [1:0] wcnt = 2'd0;
  int         n_assert = 0, n_fail = 0;

  assign ss_rdat = mreg[ss_addr];

  function automatic logic [7:0] map_init(input int s, input int i);
    if (i == 127) return 8'h2C;
    if (s == 0 && i < 14) return 8'(8'h10 + i);
    return 8'h00;
  endfunction

  function automatic logic [7:0] buf_init(input int s, input int i);
    if (s == 0) return 8'hEE;
    if (i == 127) return (s == 2) ? 8'h2D : 8'h2C;
    if (i == 5) return 8'hA7;
    if (i < 14) return 8'(8'h90 + i);
    return 8'h00;
  endfunction

  // Mapper model, buffer responder and event counters.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 256; i++) begin
        mreg[i] <= map_init(scen, i);
        bmem[i] <= buf_init(scen, i);
      end
      we_cnt <= 0; wr127 <= 0; done_cnt <= 0; overlap <= 0; wr_n <= 0;
    end else begin
      if (ss_we) begin
        mreg[ss_addr] <= ss_wdat;
        we_cnt <= we_cnt + 1;
        if (ss_addr == 8'd127) wr127 <= wr127 + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (mem_req && ss_we) overlap <= overlap + 1;
      if (mem_req && mem_ack && mem_we) begin
        bmem[mem_addr] <= mem_wdat;
        if (wr_n < 32) wr_addr[wr_n] <= mem_addr;
        wr_n <= wr_n + 1;
      end
    end
    if (!mem_req || mem_ack || !ack_en) begin
      mem_ack <= 1'b0;
      wcnt    <= 2'd0;
    end else if (wcnt == 2'd1) begin
      mem_ack  <= 1'b1;
      mem_rdat <= bmem[mem_addr];
      wcnt     <= 2'd0;
    end else begin
      wcnt <= wcnt + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_cmd(input logic s, input logic l);
    @(negedge clk); cmd_save = s; cmd_load = l;
    @(negedge clk); cmd_save = 1'b0; cmd_load = 1'b0;
  endtask

  task automatic set_scen(input int s);
    @(negedge clk); scen = s; init_req = 1'b1;
    @(negedge clk); init_req = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
    chk({tag, "_ss_act"},   32'(ss_act),   32'd0);
    chk({tag, "_ss_we"},    32'(ss_we),    32'd0);
    chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
    chk({tag, "_ss_addr"},  32'(ss_addr),  32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_save = 1'b0; cmd_load = 1'b0;
    set_scen(0);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Save: 15 buffer writes, slots 0..13 then 127.
    pulse_cmd(1'b1, 1'b0);
    wait_done(300, "save_done");
    repeat (3) @(negedge clk);
    chk("save_nwr", 32'(wr_n), 32'd15);
    for (int i = 0; i < 15; i++)
      chk($sformatf("save_addr%0d", i), 32'(wr_addr[i]), (i < 14) ? 32'(i) : 32'd127);
    chk("save_buf3", 32'(bmem[3]), 32'h13);
    chk("save_buf127", 32'(bmem[127]), 32'h2C);
    chk("save_done_cnt", 32'(done_cnt), 32'd1);
    chk("save_err", 32'(err), 32'd0);
    chk("save_no_we", 32'(we_cnt), 32'd0);

    // Load with matching ID.
    set_scen(1);
    pulse_cmd(1'b0, 1'b1);
    wait_done(300, "load_done");
    repeat (3) @(negedge clk);
    chk("load_we_cnt", 32'(we_cnt), 32'd14);
    chk("load_wr127", 32'(wr127), 32'd0);
    chk("load_slot5", 32'(mreg[5]), 32'hA7);
    chk("load_slot0", 32'(mreg[0]), 32'h90);
    chk("load_slot13", 32'(mreg[13]), 32'h9D);
    chk("load_id", 32'(mreg[127]), 32'h2C);
    chk("load_err", 32'(err), 32'd0);
    chk("load_done_cnt", 32'(done_cnt), 32'd1);

    // Load with mismatching ID.
    set_scen(2);
    pulse_cmd(1'b0, 1'b1);
    wait_done(100, "mism_done");
    repeat (3) @(negedge clk);
    chk("mism_err", 32'(err), 32'd1);
    chk("mism_we_cnt", 32'(we_cnt), 32'd0);
    chk("mism_done_cnt", 32'(done_cnt), 32'd1);
    chk("mism_slot0", 32'(mreg[0]), 32'h00);
    pulse_cmd(1'b1, 1'b0);
    chk("err_clear", 32'(err), 32'd0);
    chk("err_clear_busy", 32'(busy), 32'd1);
    wait_done(300, "err_clear_done");

    // Simultaneous commands plus a load pulse mid-save.
    set_scen(0);
    pulse_cmd(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    pulse_cmd(1'b0, 1'b1);
    wait_done(300, "both_done");
    repeat (6) @(negedge clk);
    chk("both_idle", 32'(busy), 32'd0);
    chk("both_done_cnt", 32'(done_cnt), 32'd1);
    chk("both_we_cnt", 32'(we_cnt), 32'd0);
    chk("both_nwr", 32'(wr_n), 32'd15);
    chk("both_slot5", 32'(mreg[5]), 32'h15);

    // Reset during LD_WR of slot 7.
    set_scen(1);
    pulse_cmd(1'b0, 1'b1);
    n = 0;
    while (!(ss_we === 1'b1 && ss_addr === 8'd7) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_slot7", 32'(ss_we), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    for (int i = 0; i < 7; i++)
      chk($sformatf("midrst_slot%0d", i), 32'(mreg[i]), 32'(buf_init(1, i)));
    chk("midrst_slot8", 32'(mreg[8]), 32'h00);
    rst_n = 1'b1;

    // Buffer never acknowledges.
    set_scen(0);
    ack_en = 1'b0;
    pulse_cmd(1'b1, 1'b0);
`ifdef SS_TIMEOUT_EN
    wait_done(400, "tmo_done");
    chk("tmo_err", 32'(err), 32'd1);
    @(negedge clk);
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_req", 32'(mem_req), 32'd0);
`else
    repeat (300) @(negedge clk);
    chk("hang_busy", 32'(busy), 32'd1);
    chk("hang_req", 32'(mem_req), 32'd1);
    chk("hang_no_done", 32'(done_cnt), 32'd0);
`endif
    rst_n = 1'b0;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("req_we_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/map_ss_seq.md
MAP_SS_SEQ -- requirements
Module: map_ss_seq

Interface
REQ-001 SHALL have parameter N_REGS, default 14, giving the number of mapper state slots at ss_addr 0..N_REGS-1.
REQ-002 SHALL have parameter ID_ADDR, default 127, giving the read-only mapper-index slot.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port cmd_save, input, 1, start-save request, sampled per cycle.
REQ-006 SHALL have port cmd_load, input, 1, start-restore request, sampled per cycle.
REQ-007 SHALL have port ss_act, output, 1, mapper save-state access active.
REQ-008 SHALL have port ss_we, output, 1, mapper register write strobe, one cycle.
REQ-009 SHALL have port ss_addr, output, 8, mapper save-state slot address.
REQ-010 SHALL have port ss_wdat, output, 8, data to the mapper during restore.
REQ-011 SHALL have port ss_rdat, input, 8, mapper slot readback, combinational from ss_addr.
REQ-012 SHALL have ports mem_req, mem_we, mem_addr[7:0] and mem_wdat[7:0] as outputs: backing-buffer request, write flag, address and write data.
REQ-013 SHALL have ports mem_ack (1) and mem_rdat[7:0] as inputs: buffer acknowledge and read data.
REQ-014 SHALL have outputs busy (1), done (1, one-cycle pulse) and err (1, sticky).

Function
REQ-015 SHALL use the states IDLE, SV_RD, SV_WR, LD_ID, LD_RD, LD_WR and FIN.
REQ-016 In IDLE, cmd_save SHALL go to SV_RD; cmd_load SHALL go to LD_ID; if both are high, save SHALL win; err SHALL clear on acceptance.
REQ-017 Commands arriving while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-018 The save order SHALL be slots 0..N_REGS-1, then ID_ADDR.
REQ-019 SV_RD SHALL last exactly 1 cycle with ss_act=1 and ss_addr=slot, and SHALL latch ss_rdat at the end of the cycle.
REQ-020 SV_WR SHALL hold mem_req=1, mem_we=1, mem_addr=slot and mem_wdat=latched value until mem_ack, with ss_act still 1.
REQ-021 On mem_ack in SV_WR, the block SHALL advance to the next slot in SV_RD, or to FIN after ID_ADDR.
REQ-022 LD_ID SHALL hold mem_req=1, mem_we=0, mem_addr=ID_ADDR and ss_addr=ID_ADDR with ss_act=1 until mem_ack.
REQ-023 On mem_ack in LD_ID, mem_rdat!=ss_rdat SHALL set err and go to FIN with no ss_we ever asserted; a match SHALL go to LD_RD at slot 0.
REQ-024 LD_RD SHALL read buffer[slot] with a handshake identical to REQ-022, latching mem_rdat on mem_ack.
REQ-025 LD_WR SHALL last 1 cycle with ss_act=1, ss_we=1, ss_addr=slot and ss_wdat=latched data.
REQ-026 After LD_WR the block SHALL advance to the next slot, or to FIN after slot N_REGS-1; ID_ADDR SHALL never be written.
REQ-027 FIN SHALL last 1 cycle with done=1, then return to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 ss_act, ss_we and mem_req SHALL be 0 in IDLE and FIN.
REQ-030 mem_req SHALL be deasserted in the cycle after mem_ack and SHALL never be asserted together with ss_we.
REQ-031 The slot counter SHALL be 8 bits; N_REGS SHALL be ≤ ID_ADDR, checked at elaboration.
REQ-032 Cycle count per save slot SHALL be 1 + ack latency + 1.

Reset
REQ-033 rst_n=0 at a clock edge SHALL force IDLE, slot=0, and all outputs to 0 (including err), aborting any transfer mid-operation.
REQ-034 A restore aborted by reset SHALL leave already-written mapper slots as written, with no roll-back.

Configuration
REQ-035 With SS_TIMEOUT_EN defined, an 8-bit watchdog SHALL count cycles that mem_req is held without mem_ack and reload on every new request.
REQ-036 With SS_TIMEOUT_EN defined, reaching 255 SHALL set err, drop mem_req and go to FIN.
REQ-037 With SS_TIMEOUT_EN undefined, the block SHALL wait for mem_ack indefinitely and SHALL contain no watchdog logic.

Structure
REQ-038 State encoding typedef, ID_ADDR default and timeout limit SHALL reside in the shared package map_ss_pkg.
REQ-039 The buffer handshake with watchdog SHALL be one sub-module, map_ss_hs; the FSM and slot counter SHALL stay in map_ss_seq.

Verification
REQ-040 Save with N_REGS=14, ack 2 cycles after req: the block SHALL write 15 buffer entries at addresses 0..13 then 127, in order; done SHALL pulse once; err=0.
REQ-041 Load with buffer[127]==ss_rdat(127)=0x2C and buffer[5]=0xA7: ss_we SHALL assert 14 times, at slot 5 with ss_wdat=0xA7; no write SHALL occur to 127.
REQ-042 Load with buffer[127]=0x2D and mapper id 0x2C: err=1, zero ss_we pulses, done pulses, and the next accepted command SHALL clear err.
REQ-043 cmd_save and cmd_load high in the same IDLE cycle, plus cmd_load pulsed mid-save: only a save SHALL run, exactly one done.
REQ-044 rst_n low during LD_WR of slot 7: the next cycle SHALL be IDLE with all outputs 0; slots 0..6 SHALL stay restored.
REQ-045 With SS_TIMEOUT_EN defined and mem_ack never asserted: at 255 cycles err=1 and done pulses; without the macro, busy SHALL stay 1.
